fetch_prefetch: RTL and testbench
=================================

// Module: fetch_prefetch
// PURPOSE
//  Instruction fetch front-end upstream of the RV32I datapath. Owns the fetch PC, issues
//  word reads to a variable-latency instruction memory (valid/ready request, in-order
//  response) and buffers up to DEPTH instructions in a prefetch queue.
//  Hands the core {inst, inst_pc} over a valid/ready interface. On a redirect (branch or
//  jump) it flushes the queue, discards stale responses and refetches from the new PC.
// PARAMETERS
//  XLEN      32            address/instruction width
//  DEPTH     4             queue entries = max in-flight plus buffered; power of 2, >=2
//  RESET_PC  32'h0000_0000 first fetch address after reset
// PORTS
//  clk            in   1     clock, rising edge
//  rst            in   1     asynchronous, active-low reset
//  redirect_valid in   1     flush and refetch from redirect_pc
//  redirect_pc    in   XLEN  new fetch PC; bits[1:0] ignored (forced 0)
//  imem_req_valid out  1     fetch request valid
//  imem_req_ready in   1     memory accepts request
//  imem_req_addr  out  XLEN  fetch address, word aligned
//  imem_rsp_valid in   1     response valid; in request order; earliest 1 cycle after accept
//  imem_rsp_data  in   XLEN  fetched instruction
//  inst_valid     out  1     queue head holds a filled instruction
//  inst_ready     in   1     core consumes head
//  inst           out  XLEN  instruction at head
//  inst_pc        out  XLEN  PC of inst
// BEHAVIOUR
//  - Reset (rst=0, async): queue empty, drop_cnt=0, fetch_pc=RESET_PC. Outputs:
//    imem_req_valid=0, inst_valid=0, inst=0, inst_pc=0, imem_req_addr=RESET_PC.
//    Reset mid-operation discards everything; memory side must also be reset.
//  - Issue: imem_req_valid = (alloc_cnt + drop_cnt) < DEPTH. imem_req_addr = fetch_pc.
//    On accept, allocate tail entry {pc=fetch_pc, filled=0} and set fetch_pc += 4
//    (wraps mod 2^XLEN). Req valid/addr must hold stable until accepted unless redirected.
//  - Response: if drop_cnt>0, drop_cnt-=1 and discard the data. Else write data into the
//    oldest unfilled entry and set filled=1. A response with nothing outstanding is a
//    protocol error: ignore it and raise a sim assertion.
//  - Deliver: inst_valid = head entry allocated and filled; inst/inst_pc come from
//    registered entry storage. Pop on inst_valid & inst_ready. Min latency: accept ->
//    response next cycle -> inst_valid the cycle after (2 cycles). Throughput 1/cycle.
//  - Redirect (takes priority): next cycle queue empty, fetch_pc = {redirect_pc[31:2],2'b00},
//    drop_cnt += number of allocated-unfilled entries, plus 1 if a request is accepted in
//    the redirect cycle, minus 1 if a response arrives in it (that response is discarded).
//    A pop in the redirect cycle completes normally (core already took it).
//    inst_valid=0 during the cycle after redirect.
//  - Simultaneous push/fill/pop on the same cycle are all legal. Full queue: no issue.
//    Empty: inst_valid=0. Pointers are log2(DEPTH) bits plus a wrap bit.
//  - Invariant: alloc_cnt + drop_cnt <= DEPTH. drop_cnt width is clog2(DEPTH)+1.
// STRUCTURE
//  - Shared header defines: XLEN, RESET_PC default, INST_NOP (32'h0000_0013),
//    and the entry struct layout {pc, inst, filled}.
//  - Sub-module fetch_queue: circular buffer with alloc (tail), fill and pop (head)
//    pointers; exports alloc_cnt, head_filled, head data.
//  - Top level holds fetch_pc, drop_cnt and the issue/redirect control.
// TESTING
//  1 Reset: rst=0 with stimulus toggling -> req_valid=0, inst_valid=0. Release -> first edge
//    gives req_valid=1, addr 0x0.
//  2 Stream: req_ready=1, rsp 1 cycle later, inst_ready=1 -> inst_pc 0x0,0x4,0x8,... one per
//    cycle from cycle 2 onward, inst matches the memory image.
//  3 Backpressure: inst_ready=0 -> exactly 4 accepts (0x0-0xC), then req_valid=0. Raise ready
//    -> in-order delivery, then fetch resumes at 0x10.
//  4 Redirect with 2 in flight: redirect to 0x100 -> next 2 responses dropped; first
//    inst_pc=0x100, none of 0x8/0xC ever seen.
//  5 Redirect to 0x103 in the same cycle as a request accept and a response -> fetch restarts
//    at 0x100; no stale instruction is delivered.
//  6 Random latency 1-5 cycles, random inst_ready/redirects vs reference model -> exact
//    inst/inst_pc sequence; invariant assertion never fires.

Source files
------------

// File: rtl/fetch_prefetch_pkg.sv
// Shared types and constants for the instruction fetch front-end.
// Holds the prefetch queue entry layout used by the queue and the top level.
package fetch_prefetch_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] RESET_PC_DEF = 32'h0000_0000;
    localparam logic [XLEN-1:0] INST_NOP     = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
        logic            filled;
    } entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Circular prefetch buffer with separate alloc (tail), fill and pop (head)
// pointers; each pointer carries a wrap bit so full and empty stay distinct.
module fetch_queue
    import fetch_prefetch_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PW = $clog2(DEPTH)
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            flush_i,
    input  logic            push_i,
    input  logic [XLEN-1:0] push_pc_i,
    input  logic            fill_i,
    input  logic [XLEN-1:0] fill_data_i,
    input  logic            pop_i,
    output logic [PW:0]     alloc_cnt_o,
    output logic [PW:0]     unfilled_cnt_o,
    output logic            head_filled_o,
    output logic [XLEN-1:0] head_pc_o,
    output logic [XLEN-1:0] head_inst_o
);

    entry_t      ent_q [DEPTH];
    logic [PW:0] head_q;
    logic [PW:0] fill_q;
    logic [PW:0] tail_q;
    logic        do_fill;
    entry_t      head;

    assign alloc_cnt_o    = tail_q - head_q;
    assign unfilled_cnt_o = tail_q - fill_q;
    assign do_fill        = fill_i && (fill_q != tail_q);
    assign head           = ent_q[head_q[PW-1:0]];
    assign head_filled_o  = (alloc_cnt_o != '0) && head.filled;
    assign head_pc_o      = head.pc;
    assign head_inst_o    = head.inst;

    // Flush only moves the pointers; stale storage is masked by alloc_cnt.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            head_q <= '0;
            fill_q <= '0;
            tail_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i] <= '0;
            end
        end else if (flush_i) begin
            head_q <= tail_q;
            fill_q <= tail_q;
        end else begin
            if (push_i) begin
                ent_q[tail_q[PW-1:0]] <= '{pc: push_pc_i, inst: INST_NOP, filled: 1'b0};
                tail_q <= tail_q + 1'b1;
            end
            if (do_fill) begin
                ent_q[fill_q[PW-1:0]].inst   <= fill_data_i;
                ent_q[fill_q[PW-1:0]].filled <= 1'b1;
                fill_q <= fill_q + 1'b1;
            end
            if (pop_i) begin
                head_q <= head_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/fetch_prefetch.sv
// Fetch front-end: owns the fetch PC, issues word reads to instruction memory
// and hands buffered instructions to the core; redirects flush and refetch.
module fetch_prefetch
    import fetch_prefetch_pkg::*;
#(
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [XLEN-1:0] inst,
    output logic [XLEN-1:0] inst_pc
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [XLEN-1:0] fetch_pc_q;
    logic [XLEN-1:0] fetch_pc_d;
    logic [CW-1:0]   drop_q;
    logic [CW-1:0]   drop_d;
    logic            run_q;
    logic [CW-1:0]   alloc_cnt;
    logic [CW-1:0]   unfilled_cnt;
    logic [CW:0]     inflight;
    logic            accept;
    logic            rsp_drop;
    logic            rsp_live;
    logic            head_filled;

    assign inflight       = {1'b0, alloc_cnt} + {1'b0, drop_q};
    assign imem_req_valid = run_q && (inflight < (CW+1)'(DEPTH));
    assign imem_req_addr  = fetch_pc_q;
    assign accept         = imem_req_valid && imem_req_ready;
    assign rsp_drop       = imem_rsp_valid && (drop_q != '0);
    assign rsp_live       = imem_rsp_valid && (drop_q == '0) && (unfilled_cnt != '0);
    assign inst_valid     = head_filled;

    fetch_queue #(
        .DEPTH(DEPTH)
    ) u_queue (
        .clk_i         (clk),
        .rst_ni        (rst),
        .flush_i       (redirect_valid),
        .push_i        (accept && !redirect_valid),
        .push_pc_i     (fetch_pc_q),
        .fill_i        (rsp_live && !redirect_valid),
        .fill_data_i   (imem_rsp_data),
        .pop_i         (inst_valid && inst_ready),
        .alloc_cnt_o   (alloc_cnt),
        .unfilled_cnt_o(unfilled_cnt),
        .head_filled_o (head_filled),
        .head_pc_o     (inst_pc),
        .head_inst_o   (inst)
    );

    // Everything not yet filled becomes a response to discard after a redirect.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        drop_d     = drop_q;
        if (redirect_valid) begin
            fetch_pc_d = {redirect_pc[XLEN-1:2], 2'b00};
            drop_d     = drop_q + unfilled_cnt + CW'(accept)
                       - CW'(rsp_drop || rsp_live);
        end else begin
            if (accept) begin
                fetch_pc_d = fetch_pc_q + XLEN'(4);
            end
            if (rsp_drop) begin
                drop_d = drop_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc_q <= RESET_PC;
            drop_q     <= '0;
            run_q      <= 1'b0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            drop_q     <= drop_d;
            run_q      <= 1'b1;
        end
    end

    assert property (@(posedge clk) disable iff (!rst)
        imem_rsp_valid |-> (drop_q != '0 || unfilled_cnt != '0));

    assert property (@(posedge clk) disable iff (!rst)
        inflight <= (CW+1)'(DEPTH));

endmodule

// File: tb/tb_fetch_prefetch.sv
// Scoreboard bench for fetch_prefetch: in-order memory model with variable
// latency, expected PC stream queue, and a monitor checking every delivery.
module tb_fetch_prefetch;
    import fetch_prefetch_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;

    always #5 clk = ~clk;

    fetch_prefetch #(
        .DEPTH(4),
        .RESET_PC(32'h0000_0000)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .imem_req_valid(imem_req_valid),
        .imem_req_ready(imem_req_ready),
        .imem_req_addr (imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data (imem_rsp_data),
        .inst_valid    (inst_valid),
        .inst_ready    (inst_ready),
        .inst          (inst),
        .inst_pc       (inst_pc)
    );

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;
    int rsp_cnt = 0;
    int rd_idx = 0;
    bit toggle = 1'b0;
    bit rdy_rand = 1'b0;
    bit irdy_rand = 1'b0;
    int lat_min = 1;
    int lat_max = 1;

    logic [31:0] exp_pc [$];
    logic [31:0] acc_log [$];
    int          acc_cyc [$];
    int          pop_cyc [$];
    logic [31:0] pend_a [$];
    int          pend_t [$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A3C, ~a[15:0]};
    endfunction

    function automatic int qi(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    function automatic logic [31:0] qa(input logic [31:0] q[$], input int i);
        return (i < q.size()) ? q[i] : 32'hxxxx_xxxx;
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Memory model: in-order responses, latency drawn per request.
    initial begin
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (!rst) begin
                pend_a.delete();
                pend_t.delete();
                imem_req_ready = toggle ? 1'($urandom_range(0, 1)) : 1'b0;
                imem_rsp_valid = toggle ? 1'($urandom_range(0, 1)) : 1'b0;
                imem_rsp_data  = $urandom;
            end else begin
                imem_req_ready = rdy_rand ? ($urandom_range(0, 2) != 0) : 1'b1;
                if (pend_a.size() != 0 && pend_t[0] <= cyc) begin
                    imem_rsp_valid = 1'b1;
                    imem_rsp_data  = mem_word(pend_a[0]);
                end else begin
                    imem_rsp_valid = 1'b0;
                    imem_rsp_data  = '0;
                end
            end
            @(negedge clk);
            if (rst) begin
                if (imem_rsp_valid && pend_a.size() != 0) begin
                    void'(pend_a.pop_front());
                    void'(pend_t.pop_front());
                    rsp_cnt++;
                end
                if (imem_req_valid && imem_req_ready) begin
                    acc_log.push_back(imem_req_addr);
                    acc_cyc.push_back(cyc);
                    pend_a.push_back(imem_req_addr);
                    pend_t.push_back(cyc + int'($urandom_range(lat_min, lat_max)));
                end
            end
        end
    end

    // Core side: ready only while the scoreboard expects more instructions.
    initial begin
        inst_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst) inst_ready = toggle ? 1'($urandom_range(0, 1)) : 1'b0;
            else inst_ready = (rd_idx < exp_pc.size()) &&
                              (irdy_rand ? ($urandom_range(0, 3) != 0) : 1'b1);
        end
    end

    // Monitor: compare each delivered instruction against the expected queue.
    initial begin
        forever begin
            @(negedge clk);
            if (rst && inst_valid && inst_ready) begin
                pop_cyc.push_back(cyc);
                if (rd_idx < exp_pc.size()) begin
                    check("inst_pc", inst_pc, exp_pc[rd_idx]);
                    check("inst", inst, mem_word(exp_pc[rd_idx]));
                    rd_idx++;
                end else begin
                    n_chk++;
                    $display("FAIL unexpected_pop: got pc %h expected none", inst_pc);
                end
            end
        end
    end

    task automatic do_reset(input bit tog);
        rst = 1'b0;
        toggle = tog;
        redirect_valid = 1'b0;
        repeat (4) begin
            @(posedge clk);
            #2;
            if (tog) begin
                redirect_valid = 1'($urandom_range(0, 1));
                redirect_pc = $urandom;
            end
            @(negedge clk);
            if (tog) begin
                check("rst_req_valid", 32'(imem_req_valid), 32'd0);
                check("rst_inst_valid", 32'(inst_valid), 32'd0);
                check("rst_req_addr", imem_req_addr, 32'h0);
                check("rst_inst", inst, 32'h0);
                check("rst_inst_pc", inst_pc, 32'h0);
            end
        end
        toggle = 1'b0;
        redirect_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        #2;
        rst = 1'b1;
    endtask

    task automatic push_seq(input logic [31:0] t, input int n);
        for (int i = 0; i < n; i++) exp_pc.push_back({t[31:2], 2'b00} + 32'(4 * i));
    endtask

    task automatic redirect_to(input logic [31:0] t, input int n, output int snap);
        redirect_valid = 1'b1;
        redirect_pc = t;
        @(posedge clk);
        #2;
        redirect_valid = 1'b0;
        snap = acc_log.size();
        push_seq(t, n);
    endtask

    task automatic wait_drain(input int max);
        int k = 0;
        while (rd_idx < exp_pc.size() && k < max) begin
            @(negedge clk);
            #1;
            k++;
        end
        check("drain_left", 32'(exp_pc.size() - rd_idx), 32'd0);
    endtask

    initial begin
        int ba, bp, br, snap, k;
        logic [31:0] t;
        redirect_valid = 1'b0;
        redirect_pc = '0;

        // Reset with toggling stimulus, then first fetch
        do_reset(1'b1);
        #1;
        check("rel_req_valid", 32'(imem_req_valid), 32'd0);
        @(negedge clk);
        check("first_req_valid", 32'(imem_req_valid), 32'd1);
        check("first_req_addr", imem_req_addr, 32'h0);

        // Stream at full rate
        do_reset(1'b0);
        ba = acc_log.size();
        bp = pop_cyc.size();
        push_seq(32'h0, 16);
        wait_drain(100);
        check("stream_latency", 32'(qi(pop_cyc, bp) - qi(acc_cyc, ba)), 32'd2);
        check("stream_rate", 32'(qi(pop_cyc, bp + 15) - qi(pop_cyc, bp)), 32'd15);

        // Backpressure: queue fills, then drains in order
        do_reset(1'b0);
        ba = acc_log.size();
        repeat (20) @(negedge clk);
        check("bp_accepts", 32'(acc_log.size() - ba), 32'd4);
        for (int i = 0; i < 4; i++) check("bp_addr", qa(acc_log, ba + i), 32'(4 * i));
        check("bp_req_valid", 32'(imem_req_valid), 32'd0);
        push_seq(32'h0, 8);
        wait_drain(100);
        check("bp_resume_addr", qa(acc_log, ba + 4), 32'h10);

        // Redirect with two responses in flight
        lat_min = 3;
        lat_max = 3;
        do_reset(1'b0);
        ba = acc_log.size();
        br = rsp_cnt;
        k = 0;
        do begin
            @(negedge clk);
            #1;
            k++;
        end while (!(acc_log.size() - ba == 4 && rsp_cnt - br == 2) && k < 40);
        check("inflight2_reached", 32'(k < 40), 32'd1);
        redirect_to(32'h100, 6, snap);
        wait_drain(100);
        check("redir_addr", qa(acc_log, snap), 32'h100);

        // Redirect coinciding with an accept and a response
        lat_min = 1;
        lat_max = 1;
        do_reset(1'b0);
        k = 0;
        do begin
            @(negedge clk);
            #1;
            k++;
        end while (!(imem_req_valid && imem_req_ready && imem_rsp_valid) && k < 40);
        check("coincide_reached", 32'(k < 40), 32'd1);
        redirect_to(32'h103, 6, snap);
        wait_drain(100);
        check("redir_unaligned_addr", qa(acc_log, snap), 32'h100);

        // Random latency, ready and redirect targets
        lat_min = 1;
        lat_max = 5;
        rdy_rand = 1'b1;
        irdy_rand = 1'b1;
        do_reset(1'b0);
        push_seq(32'h0, 5);
        wait_drain(200);
        for (int r = 0; r < 12; r++) begin
            @(negedge clk);
            #1;
            repeat ($urandom_range(0, 6)) @(negedge clk);
            #1;
            t = (r == 0) ? 32'hFFFF_FFF9 : $urandom;
            redirect_to(t, $urandom_range(2, 9), snap);
            wait_drain(400);
            check("rand_redir_addr", qa(acc_log, snap), {t[31:2], 2'b00});
        end
        repeat (10) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
